// File: rtl/loawa_adder_arbiter.sv
// Round-robin arbiter sharing one lower-part-OR approximate adder between N_REQ requesters.
// Optional macro LOAWA_EXACT_MODE_EN adds req_exact for per-request exact addition.
module loawa_adder_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDER_LENGTH   = 16,
  parameter int IMPRECISE_PART = 8,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDER_LENGTH-1:0] req_a,
  input  logic [N_REQ*ADDER_LENGTH-1:0] req_b,
`ifdef LOAWA_EXACT_MODE_EN
  input  logic [N_REQ-1:0]              req_exact,
`endif
  output logic [N_REQ-1:0]              req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ADDER_LENGTH:0]         rsp_sum,
  output logic [ID_W-1:0]               rsp_id
);

  localparam int P    = IMPRECISE_PART;
  localparam int HI_W = ADDER_LENGTH - P;

  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         rr_next;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_found;
  logic                    can_acc;
  logic [ADDER_LENGTH-1:0] a_sel;
  logic [ADDER_LENGTH-1:0] b_sel;
  logic [HI_W:0]           hi_sum;
  logic [ADDER_LENGTH:0]   approx_sum;
  logic [ADDER_LENGTH:0]   exact_sum;
  logic [ADDER_LENGTH:0]   next_sum;
  logic                    use_exact;

  // Reset gates acceptance so req_ready stays low while rst_n is asserted.
  assign can_acc = rst_n && (!rsp_valid || rsp_ready);

  always_comb begin
    logic [ID_W:0]   wrap_idx;
    logic [ID_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    wrap_idx    = '0;
    cand        = '0;
    if (can_acc) begin
      for (int k = 0; k < N_REQ; k++) begin
        wrap_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (wrap_idx >= (ID_W+1)'(N_REQ)) begin
          wrap_idx = wrap_idx - (ID_W+1)'(N_REQ);
        end
        cand = wrap_idx[ID_W-1:0];
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign a_sel = req_a[grant_idx*ADDER_LENGTH +: ADDER_LENGTH];
  assign b_sel = req_b[grant_idx*ADDER_LENGTH +: ADDER_LENGTH];

  // Upper part is exact with its own carry-out; lower part never carries into it.
  assign hi_sum     = {1'b0, a_sel[ADDER_LENGTH-1:P]} + {1'b0, b_sel[ADDER_LENGTH-1:P]};
  assign approx_sum = {hi_sum, a_sel[P-1:0] | b_sel[P-1:0]};
  assign exact_sum  = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef LOAWA_EXACT_MODE_EN
  assign use_exact = req_exact[grant_idx];
`else
  assign use_exact = 1'b0;
`endif

  assign next_sum = use_exact ? exact_sum : approx_sum;
  assign rr_next  = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (grant_found) begin
      rr_ptr    <= rr_next;
      rsp_valid <= 1'b1;
      rsp_sum   <= next_sum;
      rsp_id    <= grant_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loawa_adder_arbiter.sv
// Self-checking bench for loawa_adder_arbiter (N_REQ=4, ADDER_LENGTH=8, IMPRECISE_PART=4).
// Build with LOAWA_EXACT_MODE_EN defined to also exercise the exact-sum path.
module tb_loawa_adder_arbiter;

  localparam int N = 4;
  localparam int L = 8;
  localparam int P = 4;
`ifdef LOAWA_EXACT_MODE_EN
  localparam bit EXACT_EN = 1'b1;
`else
  localparam bit EXACT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N*L-1:0] req_a;
  logic [N*L-1:0] req_b;
  logic [N-1:0] req_exact;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [L:0]   rsp_sum;
  logic [1:0]   rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit         m_valid;
  logic [L:0] m_sum;
  int         m_id;
  int         m_rr;
  logic [N-1:0] exp_ready;

  loawa_adder_arbiter #(.N_REQ(N), .ADDER_LENGTH(L), .IMPRECISE_PART(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef LOAWA_EXACT_MODE_EN
    .req_exact (req_exact),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [L:0] ref_sum(int a, int b, bit ex);
    int lo, hi;
    if (ex) return 9'(a + b);
    lo = (a | b) % (1 << P);
    hi = a / (1 << P) + b / (1 << P);
    return 9'(hi * (1 << P) + lo);
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_sum   = '0;
    m_id    = 0;
    m_rr    = 0;
  endtask

  task automatic predict();
    bit found;
    found = 1'b0;
    exp_ready = '0;
    if (rst_n && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!found && req_valid[2'(idx)]) begin
          found = 1'b1;
          exp_ready[2'(idx)] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    int g;
    predict();
    @(posedge clk);
    g = -1;
    for (int i = 0; i < N; i++) if (exp_ready[2'(i)]) g = i;
    if (g >= 0) begin
      m_sum   = ref_sum(int'(req_a[g*L +: L]), int'(req_b[g*L +: L]), EXACT_EN && req_exact[2'(g)]);
      m_id    = g;
      m_valid = 1'b1;
      m_rr    = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_op(int i, int a, int b);
    req_a[i*L +: L] = 8'(a);
    req_b[i*L +: L] = 8'(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_exact = '0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'($urandom);
    req_valid = 4'($urandom_range(1, 15));
    req_a = $urandom;
    req_b = $urandom;
    req_exact = '0;
    m_reset();
    #1;
    n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_sum !== 9'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 000", rsp_sum); end
    @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready_clk: got %b want 0000", req_ready); end
    rst_n = 1'b1;
    #1;
    predict();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_sum !== 9'h0) begin n_fail++; $display("FAIL release_sum: got %h want 000", rsp_sum); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL release_id: got %0d want 0", rsp_id); end
    n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL release_ready: got %b want %b", req_ready, exp_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 8'h0F, 8'h01);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    n_checks++; if (rsp_sum !== 9'h00F) begin n_fail++; $display("FAIL single_sum_0f: got %h want 00f", rsp_sum); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    set_op(0, 8'hFF, 8'hFF);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready2: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (rsp_sum !== 9'h1EF) begin n_fail++; $display("FAIL single_sum_ff: got %h want 1ef", rsp_sum); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id2: got %0d want 0", rsp_id); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++; if (req_ready !== 4'(1 << (c % N))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % N))); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", c, rsp_valid); end
      n_checks++; if (rsp_id !== 2'(c % N)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d want %0d", c, rsp_id, c % N); end
      n_checks++; if (rsp_sum !== m_sum) begin n_fail++; $display("FAIL rr_sum[%0d]: got %h want %h", c, rsp_sum, m_sum); end
      set_op(c % N, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int a, b;
    logic [L:0] held;
    do_reset();
    rsp_ready = 1'b1;
    a = int'($urandom_range(0, 255));
    b = int'($urandom_range(0, 255));
    held = ref_sum(a, b, 1'b0);
    set_op(2, a, b);
    req_valid = 4'b0100;
    tick();
    for (int i = 0; i < N; i++) if (i != 2) set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    set_op(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
      n_checks++; if (rsp_sum !== held) begin n_fail++; $display("FAIL bp_sum[%0d]: got %h want %h", c, rsp_sum, held); end
      n_checks++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want 2", c, rsp_id); end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1000", req_ready); end
    tick();
    n_checks++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL bp_release_id: got %0d want 3", rsp_id); end
    n_checks++; if (rsp_sum !== m_sum) begin n_fail++; $display("FAIL bp_release_sum: got %h want %h", rsp_sum, m_sum); end
    req_valid = '0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    req_valid = 4'b0100;
    tick();
    set_op(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ready: got %b want 0010", req_ready); end
    tick();
    n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL wrap_id: got %0d want 1", rsp_id); end
    n_checks++; if (rsp_sum !== m_sum) begin n_fail++; $display("FAIL wrap_sum: got %h want %h", rsp_sum, m_sum); end
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_next_ptr: got %b want 0100", req_ready); end
    rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_sum !== 9'h0) begin n_fail++; $display("FAIL async_sum: got %h want 000", rsp_sum); end
    n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL async_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef LOAWA_EXACT_MODE_EN
  task automatic test_exact();
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, 8'hFF, 8'hFF);
    req_exact = 4'b0100;
    req_valid = 4'b0100;
    tick();
    n_checks++; if (rsp_sum !== 9'h1FE) begin n_fail++; $display("FAIL exact_on: got %h want 1fe", rsp_sum); end
    req_exact = 4'b0000;
    tick();
    n_checks++; if (rsp_sum !== 9'h1EF) begin n_fail++; $display("FAIL exact_off: got %h want 1ef", rsp_sum); end
    req_valid = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 4'($urandom);
    for (int c = 0; c < 300; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_ready); end
      tick();
      n_checks++; if (rsp_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (rsp_sum !== m_sum) begin n_fail++; $display("FAIL rand_sum[%0d]: got %h want %h", c, rsp_sum, m_sum); end
        n_checks++; if (rsp_id !== 2'(m_id)) begin n_fail++; $display("FAIL rand_id[%0d]: got %0d want %0d", c, rsp_id, m_id); end
      end
      // Requesters only change after their grant or while idle.
      for (int i = 0; i < N; i++) begin
        if (exp_ready[2'(i)] || !req_valid[2'(i)]) begin
          req_valid[2'(i)] = 1'($urandom);
          req_exact[2'(i)] = 1'($urandom);
          set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
      end
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_exact = '0;
    rsp_ready = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
`ifdef LOAWA_EXACT_MODE_EN
    test_exact();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
